// File: rtl/sum_acc_pkg.sv
// Shared types and default sizing for the adder-sum accumulator.
// The adder bench also uses these defaults.
package sum_acc_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

    localparam int DEF_COUNT = 8;
    localparam int DEF_IN_W  = 5;
    localparam int DEF_ACC_W = 8;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/sum_accumulator_sat_add.sv
// Combinational unsigned saturating adder.
// Clamps to all-ones on carry out.
module sat_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b};
        ovf  = full[W];
        sum  = full[W] ? {W{1'b1}} : full[W-1:0];
    end

endmodule

// File: rtl/sum_accumulator.sv
// Block accumulator behind the ripple adder: saturating sum of
// COUNT samples, presented with count and sticky overflow flag.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int COUNT = DEF_COUNT,
    parameter int IN_W  = DEF_IN_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  sum_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready
);

    acc_state_e       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             sat;

    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;
    logic             last;

    sat_add #(
        .W (ACC_W)
    ) u_sat_add (
        .a   (acc),
        .b   (ACC_W'(sum_in)),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign cnt_inc   = cnt + CNT_W'(1);
    assign last      = (cnt_inc == CNT_W'(COUNT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (accept) begin
                        acc <= add_sum;
                        cnt <= cnt_inc;
                        sat <= sat | add_ovf;
                        if (last || flush)
                            state <= HOLD;
                    end else if (flush && cnt != '0) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    // Result handed off: start the next block clean.
                    if (out_ready) begin
                        state <= ACCUM;
                        acc   <= '0;
                        cnt   <= '0;
                        sat   <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign out_sum = acc;
    assign out_cnt = cnt;
    assign out_sat = sat;

endmodule
